// File: rtl/input_sequencer.sv
// input_sequencer
//   Turns seven asynchronous push buttons into a stream of one-at-a-time
//   commands. Each button is synchronized, debounced and edge-detected;
//   direction keys additionally auto-repeat while held. Press events set a
//   per-button pending bit, and a single output slot presents the
//   highest-priority pending button to the consumer.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   [6:0] {reset_blue, reset_red, decision, up, down, left, right}
//   dir_en     in   accept direction presses (bits 3:0) when high
//   cmd_ready  in   consumer takes the presented command this cycle
//   clr_drop   in   clears the sticky dropped flag
//   cmd_valid  out  a command is presented
//   cmd_code   out  [2:0] up=0 down=1 left=2 right=3 decision=4 red=5 blue=6 none=7
//   pending    out  [6:0] pending-request mask, btn_raw bit order
//   dropped    out  sticky: a press hit an already-pending button
//
// Slot FSM
//   state   | meaning
//   S_EMPTY | nothing presented, cmd_code=7
//   S_FULL  | code_q presented on cmd_code with cmd_valid=1
module input_sequencer #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned REPEAT_DLY   = 16,
  parameter int unsigned REPEAT_PER   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn_raw,
  input  logic       dir_en,
  input  logic       cmd_ready,
  input  logic       clr_drop,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [6:0] pending,
  output logic       dropped
);

  // Debounce counter only ever reaches DEBOUNCE_CYC-1; repeat timer only
  // ever holds REPEAT_DLY-1 or REPEAT_PER-1.
  localparam int unsigned CW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [6:0]  DIR_MASK = 7'b000_1111;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  logic [6:0]          sync1_q, sync2_q;
  logic [6:0]          lvl_q, lvl_d, lvl_prev_q;
  logic [6:0][CW-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0][RW-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic [3:0]          rpt_fire;
  logic [6:0]          rise, press_q, press_d, acc;
  logic [6:0]          pending_q, pending_d, grant, cand;
  logic                dropped_q, dropped_d, drop_hit, load;
  logic [2:0]          code_q, code_d, sel;
  state_t              state_q, state_d;

  function automatic logic [2:0] code_of(input logic [2:0] b);
    return (b < 3'd4) ? (3'd3 - b) : b;
  endfunction

  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 7; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
        lvl_d[i]    = ~lvl_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = lvl_q & ~lvl_prev_q;

  // Down-counter per direction key: loaded on the original press, fires at
  // terminal count and reloads with the repeat period.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = '0;
    for (int i = 0; i < 4; i++) begin
      if (!lvl_q[i]) begin
        rpt_cnt_d[i] = '0;
      end else if (rise[i]) begin
        rpt_cnt_d[i] = RW'(REPEAT_DLY - 1);
      end else if (rpt_cnt_q[i] == '0) begin
        rpt_fire[i]  = 1'b1;
        rpt_cnt_d[i] = RW'(REPEAT_PER - 1);
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] - 1'b1;
      end
    end
  end

  assign press_d = rise | {3'b000, rpt_fire};
  assign acc     = press_q & ~({7{~dir_en}} & DIR_MASK);

  // Next-state: a consuming FULL slot may pick up a press arriving this edge.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cand    = pending_q;
    load    = 1'b0;
    grant   = '0;
    sel     = '0;
    case (state_q)
      S_EMPTY: load = |pending_q;
      S_FULL: begin
        if (cmd_ready) begin
          cand = pending_q | acc;
          if (|cand) load = 1'b1;
          else       state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (load) begin
      for (int i = 0; i < 7; i++) begin
        if (cand[i]) sel = 3'(i);
      end
      grant[sel] = 1'b1;
      code_d     = code_of(sel);
      state_d    = S_FULL;
    end
  end

  // A granted bit that was already pending is re-armed by a same-edge press;
  // a granted bit that came only from this edge's press is consumed outright.
  always_comb begin
    drop_hit  = |(acc & pending_q & ~grant);
    pending_d = (pending_q & ~grant) | (acc & ~(grant & ~pending_q));
    if (drop_hit)      dropped_d = 1'b1;
    else if (clr_drop) dropped_d = 1'b0;
    else               dropped_d = dropped_q;
  end

  always_comb begin
    cmd_valid = (state_q == S_FULL);
    cmd_code  = (state_q == S_FULL) ? code_q : 3'd7;
    pending   = pending_q;
    dropped   = dropped_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      db_cnt_q   <= '0;
      rpt_cnt_q  <= '0;
      press_q    <= '0;
      pending_q  <= '0;
      dropped_q  <= 1'b0;
      code_q     <= 3'd7;
      state_q    <= S_EMPTY;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      db_cnt_q   <= db_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      press_q    <= press_d;
      pending_q  <= pending_d;
      dropped_q  <= dropped_d;
      code_q     <= code_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_input_sequencer.sv
module tb_input_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] btn_raw;
  logic       dir_en, cmd_ready, clr_drop;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [6:0] pending;
  logic       dropped;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int grant_cyc[$];

  input_sequencer #(.DEBOUNCE_CYC(4), .REPEAT_DLY(16), .REPEAT_PER(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .dir_en(dir_en),
    .cmd_ready(cmd_ready), .clr_drop(clr_drop), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .pending(pending), .dropped(dropped));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Everything in the main sequence happens 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Scoreboard: a command is consumed at the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      grant_cyc.push_back(cyc);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed code %0d expected no command", cmd_code);
      end
      if (exp_q.size() != 0) chk("sb_code", cmd_code, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; btn_raw = '0; dir_en = 1'b1; cmd_ready = 1'b0; clr_drop = 1'b0;
    step(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_code", cmd_code, 7);
    chk("rst_pending", pending, 0);
    chk("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    step(2);

    // decision latency and hold while not ready
    btn_raw[4] = 1'b1;
    step(8);
    chk("lat_valid_e7", cmd_valid, 0);
    step(1);
    chk("lat_valid_e8", cmd_valid, 1);
    chk("lat_code_e8", cmd_code, 4);
    chk("lat_pending_e8", pending, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("hold_valid", cmd_valid, 1);
      chk("hold_code", cmd_code, 4);
    end

    // re-press decision while presented: pending, then drop, then clear
    btn_raw[4] = 1'b0; step(8);
    btn_raw[4] = 1'b1; step(10);
    chk("repress_pending", pending, 7'h10);
    chk("repress_dropped", dropped, 0);
    btn_raw[4] = 1'b0; step(8);
    btn_raw[4] = 1'b1; step(10);
    chk("drop_dropped", dropped, 1);
    chk("drop_pending", pending, 7'h10);
    chk("drop_code", cmd_code, 4);
    clr_drop = 1'b1; step(1);
    clr_drop = 1'b0;
    chk("clr_dropped", dropped, 0);
    btn_raw[4] = 1'b0;
    exp_q.push_back(4); exp_q.push_back(4);
    cmd_ready = 1'b1;
    step(3);
    chk("drain_valid", cmd_valid, 0);
    chk("drain_code", cmd_code, 7);
    chk("drain_pending", pending, 0);
    step(8);

    // glitch of 3 cycles is rejected, 4 cycles is accepted
    btn_raw[3] = 1'b1; step(3);
    btn_raw[3] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("glitch_valid", cmd_valid, 0);
      chk("glitch_pending", pending, 0);
    end
    exp_q.push_back(0);
    btn_raw[3] = 1'b1; step(4);
    btn_raw[3] = 1'b0; step(12);

    // up + right together, ready held: back-to-back then empty
    exp_q.push_back(0); exp_q.push_back(3);
    btn_raw[3] = 1'b1; btn_raw[0] = 1'b1;
    step(9);
    chk("pair_v8", cmd_valid, 1);
    chk("pair_c8", cmd_code, 0);
    step(1);
    chk("pair_v9", cmd_valid, 1);
    chk("pair_c9", cmd_code, 3);
    step(1);
    chk("pair_v10", cmd_valid, 0);
    chk("pair_c10", cmd_code, 7);
    btn_raw = '0; step(10);

    // direction press discarded while dir_en low
    dir_en = 1'b0;
    btn_raw[2] = 1'b1; step(12);
    chk("dis_valid", cmd_valid, 0);
    chk("dis_pending", pending, 0);
    chk("dis_dropped", dropped, 0);
    btn_raw[2] = 1'b0; step(10);
    dir_en = 1'b1;

    // simultaneous blue, red, right with ready low: priority order
    cmd_ready = 1'b0;
    btn_raw[6] = 1'b1; btn_raw[5] = 1'b1; btn_raw[0] = 1'b1;
    step(9);
    chk("prio_code", cmd_code, 6);
    chk("prio_pending", pending, 7'h21);
    btn_raw = '0;
    exp_q.push_back(6); exp_q.push_back(5); exp_q.push_back(3);
    cmd_ready = 1'b1;
    step(12);
    chk("prio_drain_pending", pending, 0);

    // auto-repeat on left held for 40 cycles
    grant_cyc.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(2);
    btn_raw[1] = 1'b1; step(40);
    btn_raw[1] = 1'b0; step(30);
    chk("rpt_count", grant_cyc.size(), 4);
    if (grant_cyc.size() == 4) begin
      chk("rpt_off1", grant_cyc[1] - grant_cyc[0], 16);
      chk("rpt_off2", grant_cyc[2] - grant_cyc[0], 24);
      chk("rpt_off3", grant_cyc[3] - grant_cyc[0], 32);
    end

    // reset mid-FULL with pending; decision held through reset release
    cmd_ready = 1'b0;
    btn_raw[4] = 1'b1; btn_raw[3] = 1'b1;
    step(10);
    chk("pre_rst_valid", cmd_valid, 1);
    chk("pre_rst_pending", pending, 7'h08);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", cmd_valid, 0);
    chk("async_rst_code", cmd_code, 7);
    chk("async_rst_pending", pending, 0);
    btn_raw[3] = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(8);
    chk("held_rst_v7", cmd_valid, 0);
    step(1);
    chk("held_rst_v8", cmd_valid, 1);
    chk("held_rst_c8", cmd_code, 4);
    exp_q.push_back(4);
    cmd_ready = 1'b1;
    btn_raw = '0;
    step(10);

    chk("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
